// File: rtl/matrix_alu_pkg.sv
// Shared constants and encodings for the matrix ALU: dimension/index widths,
// operation codes and controller states.
package matrix_alu_pkg;

  localparam int unsigned WIDTH_BIT = 2;
  localparam int unsigned INDEX_BIT = 4;
  localparam int unsigned WORD_W    = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_TRN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/matrix_alu_mac32.sv
// Combinational 32-bit multiply-accumulate; keeps only the low 32 bits.
module mac32
  import matrix_alu_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] acc,
  output logic [WORD_W-1:0] sum_c
);

  logic [WORD_W-1:0] prod;

  assign prod  = a * b;
  assign sum_c = acc + prod;

endmodule

// File: rtl/matrix_alu.sv
// Multi-cycle matrix engine: one element-operation per cycle into a result
// buffer, then a single-cycle write-back of the whole matrix.
module matrix_alu #(
  parameter int unsigned WIDTH     = 2 ** matrix_alu_pkg::WIDTH_BIT,
  parameter int unsigned INDEX_BIT = matrix_alu_pkg::INDEX_BIT
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          start,
  input  logic [1:0]                    op,
  input  logic [INDEX_BIT-1:0]          src1,
  input  logic [INDEX_BIT-1:0]          src2,
  input  logic [INDEX_BIT-1:0]          dst,
  input  logic                          gen_in,
  input  logic [WIDTH*WIDTH*32-1:0]     data1,
  input  logic [WIDTH*WIDTH*32-1:0]     data2,
  output logic [INDEX_BIT-1:0]          read1,
  output logic [INDEX_BIT-1:0]          read2,
  output logic                          generated_enable,
  output logic                          write_enable,
  output logic [INDEX_BIT-1:0]          write,
  output logic [WIDTH*WIDTH*32-1:0]     write_data,
  output logic                          busy,
  output logic                          done
);

  import matrix_alu_pkg::*;

  // WIDTH is a power of two, so {row, col, word-bit} concatenation is a flat offset
  localparam int unsigned MW = WIDTH * WIDTH * WORD_W;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned LW = $clog2(WORD_W);
  localparam int unsigned AW = $clog2(MW);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [INDEX_BIT-1:0] read1_q, read1_d;
  logic [INDEX_BIT-1:0] read2_q, read2_d;
  logic [INDEX_BIT-1:0] dst_q, dst_d;
  logic [INDEX_BIT-1:0] write_q, write_d;
  logic                 gen_q, gen_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 we_q, we_d;
  logic [CW-1:0]        i_q, i_d;
  logic [CW-1:0]        j_q, j_d;
  logic [CW-1:0]        k_q, k_d;
  logic [WORD_W-1:0]    acc_q, acc_d;
  logic [MW-1:0]        res_q, res_d;

  logic [AW-1:0]        off_ij, off_ji, off_ik, off_kj;
  logic [WORD_W-1:0]    a_ij, b_ij, a_ji, a_ik, b_kj;
  logic [WORD_W-1:0]    mac_sum;
  logic [WORD_W-1:0]    elem_val;
  logic                 elem_done;

  assign off_ij = AW'({i_q, j_q, {LW{1'b0}}});
  assign off_ji = AW'({j_q, i_q, {LW{1'b0}}});
  assign off_ik = AW'({i_q, k_q, {LW{1'b0}}});
  assign off_kj = AW'({k_q, j_q, {LW{1'b0}}});

  assign a_ij = data1[off_ij +: WORD_W];
  assign b_ij = data2[off_ij +: WORD_W];
  assign a_ji = data1[off_ji +: WORD_W];
  assign a_ik = data1[off_ik +: WORD_W];
  assign b_kj = data2[off_kj +: WORD_W];

  mac32 u_mac (
    .a     (a_ik),
    .b     (b_kj),
    .acc   (acc_q),
    .sum_c (mac_sum)
  );

  // Next-state, counter and result-buffer logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    read1_d   = read1_q;
    read2_d   = read2_q;
    dst_d     = dst_q;
    gen_d     = gen_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    we_d      = 1'b0;
    write_d   = '0;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    acc_d     = acc_q;
    res_d     = res_q;
    elem_done = 1'b0;

    unique case (op_q)
      OP_ADD:  elem_val = a_ij + b_ij;
      OP_SUB:  elem_val = a_ij - b_ij;
      OP_TRN:  elem_val = a_ji;
      default: elem_val = mac_sum;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          op_d    = op_e'(op);
          read1_d = src1;
          read2_d = src2;
          dst_d   = dst;
          gen_d   = gen_in;
          busy_d  = 1'b1;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          res_d   = '0;
        end
      end

      S_RUN: begin
        if (op_q == OP_MUL) begin
          if (k_q == LAST) begin
            res_d[off_ij +: WORD_W] = mac_sum;
            acc_d     = '0;
            k_d       = '0;
            elem_done = 1'b1;
          end else begin
            acc_d = mac_sum;
            k_d   = k_q + CW'(1);
          end
        end else begin
          res_d[off_ij +: WORD_W] = elem_val;
          elem_done = 1'b1;
        end

        if (elem_done) begin
          if (j_q == LAST) begin
            j_d = '0;
            i_d = i_q + CW'(1);
          end else begin
            j_d = j_q + CW'(1);
          end
          if ((i_q == LAST) && (j_q == LAST)) begin
            state_d = S_WB;
            we_d    = 1'b1;
            done_d  = 1'b1;
            write_d = dst_q;
          end
        end
      end

      S_WB: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        read1_d = '0;
        read2_d = '0;
        gen_d   = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        read1_d = '0;
        read2_d = '0;
        gen_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      read1_q <= '0;
      read2_q <= '0;
      dst_q   <= '0;
      write_q <= '0;
      gen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      read1_q <= read1_d;
      read2_q <= read2_d;
      dst_q   <= dst_d;
      write_q <= write_d;
      gen_q   <= gen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign read1            = read1_q;
  assign read2            = read2_q;
  assign generated_enable = gen_q;
  assign write_enable     = we_q;
  assign write            = write_q;
  assign write_data       = res_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_matrix_alu.sv
// Self-checking bench for matrix_alu with a behavioural matrix memory and a
// write-back scoreboard.
module tb_matrix_alu;
  import matrix_alu_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned IB = 4;
  localparam int unsigned MW = W * W * 32;

  typedef logic [MW-1:0] mat_t;

  typedef struct {
    logic [IB-1:0] dst;
    mat_t          data;
    int            lat;
    int            t0;
  } sb_t;

  typedef struct {
    logic [1:0]    op;
    logic [IB-1:0] s1;
    logic [IB-1:0] s2;
    logic [IB-1:0] d;
    logic          g;
    int            ak;
    logic [31:0]   av;
    int            bk;
    logic [31:0]   bv;
    logic [31:0]   exp00;
    int            lat;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op_in;
  logic [IB-1:0] src1_in, src2_in, dst_in;
  logic          gen_in;
  mat_t          data1, data2;
  logic [IB-1:0] read1, read2, write;
  logic          generated_enable, write_enable, busy, done;
  mat_t          write_data;

  mat_t mem [2**IB];
  sb_t  sb_q[$];
  vec_t vecs[8];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  matrix_alu #(.WIDTH(W), .INDEX_BIT(IB)) dut (
    .CLK              (clk),
    .RST              (rst_n),
    .start            (start),
    .op               (op_in),
    .src1             (src1_in),
    .src2             (src2_in),
    .dst              (dst_in),
    .gen_in           (gen_in),
    .data1            (data1),
    .data2            (data2),
    .read1            (read1),
    .read2            (read2),
    .generated_enable (generated_enable),
    .write_enable     (write_enable),
    .write            (write),
    .write_data       (write_data),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] el(input mat_t m, input int i, input int j);
    return m[(i*W + j)*32 +: 32];
  endfunction

  function automatic mat_t gen_mat(input logic [IB-1:0] v);
    mat_t m;
    for (int i = 0; i < W*W; i++) m[i*32 +: 32] = 32'(v);
    return m;
  endfunction

  // kind 0: constant v; 1: ramp i*W+j+v; 2: identity
  function automatic mat_t fill(input int kind, input logic [31:0] v);
    mat_t m;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        case (kind)
          0:       m[(i*W + j)*32 +: 32] = v;
          1:       m[(i*W + j)*32 +: 32] = 32'(i*W + j) + v;
          default: m[(i*W + j)*32 +: 32] = (i == j) ? 32'd1 : 32'd0;
        endcase
    return m;
  endfunction

  function automatic mat_t model(input logic [1:0] op, input mat_t a, input mat_t b);
    mat_t r;
    logic [31:0] s;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++) begin
        if (op == OP_ADD)      s = el(a, i, j) + el(b, i, j);
        else if (op == OP_SUB) s = el(a, i, j) - el(b, i, j);
        else if (op == OP_TRN) s = el(a, j, i);
        else begin
          s = 32'd0;
          for (int k = 0; k < W; k++) s = s + el(a, i, k) * el(b, k, j);
        end
        r[(i*W + j)*32 +: 32] = s;
      end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chkm(input string name, input mat_t act, input mat_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Combinational memory read ports plus generated-constant B
  assign data1 = mem[read1];
  assign data2 = generated_enable ? gen_mat(read2) : mem[read2];

  always @(posedge clk) if (write_enable) mem[write] = write_data;

  // Scoreboard: every write-back pops one expected result
  always @(negedge clk) begin
    if (rst_n && write_enable) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", 32'(write_enable), 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("wb_index", 32'(write), 32'(e.dst));
        chkm("wb_data", write_data, e.data);
        chk("wb_latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
        chk("wb_done", 32'(done), 32'd1);
      end
    end
  end

  task automatic run_op(input vec_t v, input int glitch, input logic [IB-1:0] alt);
    mat_t a, b;
    sb_t  s;
    int   n;
    @(negedge clk);
    if (!v.g) mem[v.s2] = fill(v.bk, v.bv);
    mem[v.s1] = fill(v.ak, v.av);
    a = mem[v.s1];
    b = v.g ? gen_mat(v.s2) : mem[v.s2];
    start   = 1'b1;
    op_in   = v.op;
    src1_in = v.s1;
    src2_in = v.s2;
    dst_in  = v.d;
    gen_in  = v.g;
    @(posedge clk);
    #1;
    start  = 1'b0;
    s.dst  = v.d;
    s.data = model(v.op, a, b);
    s.lat  = v.lat;
    s.t0   = cyc;
    sb_q.push_back(s);
    @(negedge clk);
    chk("run_read1", 32'(read1), 32'(v.s1));
    chk("run_read2", 32'(read2), 32'(v.s2));
    chk("run_gen_en", 32'(generated_enable), 32'(v.g));
    chk("run_busy", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 300) begin
      if (n == glitch) begin
        start  = 1'b1;
        dst_in = alt;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      chk("done_timeout", 32'(done), 32'd1);
    end else begin
      @(posedge clk);
      #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_read1", 32'(read1), 32'd0);
      chk("elem00", el(write_data, 0, 0), v.exp00);
    end
  endtask

  initial begin
    mat_t pre;
    vec_t rv;
    rst_n   = 1'b0;
    start   = 1'b0;
    op_in   = 2'b00;
    src1_in = '0;
    src2_in = '0;
    dst_in  = '0;
    gen_in  = 1'b0;
    for (int i = 0; i < 2**IB; i++) mem[i] = '0;

    vecs[0] = '{OP_ADD, 4'd1,  4'd2,  4'd3,  1'b0, 0, 32'hFFFF_FFFF, 0, 32'd1,       32'h0,         17};
    vecs[1] = '{OP_MUL, 4'd1,  4'd5,  4'd1,  1'b1, 2, 32'd0,         0, 32'd0,       32'd5,         65};
    vecs[2] = '{OP_MUL, 4'd4,  4'd6,  4'd7,  1'b0, 0, 32'h0001_0000, 0, 32'h1_0000,  32'h0,         65};
    vecs[3] = '{OP_MUL, 4'd4,  4'd6,  4'd7,  1'b0, 0, 32'd3,         0, 32'd3,       32'd36,        65};
    vecs[4] = '{OP_SUB, 4'd2,  4'd3,  4'd9,  1'b0, 1, 32'd0,         0, 32'd1,       32'hFFFF_FFFF, 17};
    vecs[5] = '{OP_TRN, 4'd2,  4'd3,  4'd10, 1'b0, 1, 32'd0,         0, 32'd7,       32'h0,         17};
    vecs[6] = '{OP_MUL, 4'd11, 4'd12, 4'd13, 1'b0, 1, 32'd0,         1, 32'd0,       32'd56,        65};
    vecs[7] = '{OP_ADD, 4'd14, 4'd9,  4'd14, 1'b1, 1, 32'd0,         0, 32'd0,       32'd9,         17};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_read1", 32'(read1), 32'd0);
    chk("rst_read2", 32'(read2), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_gen_en", 32'(generated_enable), 32'd0);
    chkm("rst_write_data", write_data, '0);
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) run_op(vecs[t], -1, '0);

    // start while busy must be ignored
    mem[15] = fill(0, 32'h5A5A);
    pre = mem[15];
    run_op(vecs[0], 4, 4'd15);
    repeat (3) @(negedge clk);
    chkm("glitch_dst_untouched", mem[15], pre);
    chk("glitch_not_queued", 32'(busy), 32'd0);

    // reset mid-MUL aborts without a write
    @(negedge clk);
    mem[1] = fill(0, 32'd3);
    mem[2] = fill(0, 32'd3);
    mem[8] = fill(0, 32'hAAAA);
    pre = mem[8];
    start   = 1'b1;
    op_in   = OP_MUL;
    src1_in = 4'd1;
    src2_in = 4'd2;
    dst_in  = 4'd8;
    gen_in  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_we", 32'(write_enable), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_read1", 32'(read1), 32'd0);
    chkm("abort_write_data", write_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chkm("abort_dst_untouched", mem[8], pre);
    rv = '{OP_MUL, 4'd1, 4'd2, 4'd8, 1'b0, 0, 32'd3, 0, 32'd3, 32'd36, 65};
    run_op(rv, -1, '0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/matrix_alu.md
# matrix_alu

Multi-cycle matrix arithmetic engine that sits directly downstream of the matrix `memory` block and feeds its write port. It reads two source matrices through the memory's combinational read ports, computes an elementwise or matrix-product result one element-operation per cycle into an internal result buffer, and writes the whole result matrix back in a single write cycle. Control logic issues one operation at a time using a start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, default `2**WIDTH_BIT`: matrix dimension; matrices are WIDTH×WIDTH of 32-bit words.
- `INDEX_BIT`, default `` `INDEX_BIT ``: width of the matrix index (address).

Ports:
- `CLK`  in  1  the single clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `op`  in  2  operation: 00 ADD, 01 SUB, 10 MUL (matrix product), 11 TRN (transpose of src1).
- `src1`, `src2`, `dst`  in  INDEX_BIT each  source A, source B and destination matrix indices.
- `gen_in`  in  1  use the generated constant matrix for B, where every element equals `src2`.
- `data1`, `data2`  in  WIDTH×WIDTH×32  matrices from the memory read ports, valid in the same cycle.
- `read1`, `read2`  out  INDEX_BIT each  memory read indices.
- `generated_enable`  out  1  drives the memory's generated-matrix select.
- `write_enable`  out  1  memory write strobe.
- `write`  out  INDEX_BIT  memory write index.
- `write_data`  out  WIDTH×WIDTH×32  result matrix.
- `busy`  out  1  high from the cycle after `start` is accepted through the write-back cycle.
- `done`  out  1  one-cycle pulse in the write-back cycle.

## Operation
- States are IDLE, RUN and WB.
- **IDLE**
  - On `start`=1, latch `op`, `src1`, `src2`, `dst` and `gen_in`.
  - Clear counters i, j, k, the accumulator and the result buffer, then go to RUN.
- **Read outputs:** `read1`, `read2` and `generated_enable` come from the latched registers while busy and are 0 in IDLE.
- **RUN, elementwise ops (ADD/SUB/TRN)**
  - Each cycle, `res[i][j]` is set to `A[i][j]+B[i][j]`, `A[i][j]-B[i][j]` or `A[j][i]` respectively.
  - Then j increments; when j wraps, i increments.
  - After element (W-1, W-1), go to WB.
- **RUN, MUL**
  - Each cycle, `acc` is updated to `acc + A[i][k]*B[k][j]`.
  - k increments. When k=W-1, write `acc`+product to `res[i][j]`, clear `acc`, clear k and advance j/i as above.
  - After (W-1, W-1, W-1), go to WB.
- **Arithmetic:** all 32-bit, wrapping. A product keeps its low 32 bits. Sign does not matter.
- **WB**
  - `write_enable`=1, `write`=`dst`, `write_data`=`res`, `done`=1. Go to IDLE.
- **Outside WB:** `write_enable`=0. `write_data` continuously reflects `res`.
- **Aliasing:** `dst` equal to `src1` or `src2` is legal. Sources are never modified before WB, so the result is exact.
- **`start` while busy:** ignored, with no queueing.
- **Reset (`RST`=0), at any time including mid-operation**
  - Go to IDLE immediately and abort; no write occurs.
  - All outputs, counters and `res` go to 0.

## Timing
- Reset values: `busy`, `done`, `write_enable`, `read1`, `read2`, `write`, `generated_enable` = 0. `write_data` = all zeros.
- Start is accepted at edge E0; RUN occupies the following cycles.
- Elementwise ops: W² RUN cycles; WB is cycle W²+1 after E0. For W=4, `done` is high 17 cycles after E0.
- MUL: W³ RUN cycles; WB is cycle W³+1. For W=4, that is 65 cycles.
- A new `start` is accepted in the cycle after WB (IDLE) at the earliest. Back-to-back throughput is therefore W²+2 or W³+2 cycles per operation.
- Memory reads are combinational. A write-back is visible on the memory read ports in the cycle after WB.

## Structure
- Shared package/header (`CONSTANT.v` scope):
  - `WIDTH_BIT` and `INDEX_BIT`.
  - Op encodings `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_TRN`.
  - State encodings `S_IDLE`, `S_RUN`, `S_WB`.
- One sub-module, `mac32`: a combinational 32-bit multiply-accumulate, low 32 bits, used in RUN for MUL.
- Element select and result-buffer indexing are inline, using `i`/`j`/`k` counters of WIDTH_BIT bits each.

## Test plan
- **ADD with overflow (W=4):** mem[1] all 0xFFFFFFFF, mem[2] all 1; ADD src1=1 src2=2 dst=3 → WB at +17 cycles with `write`=3, mem[3] all 0.
- **MUL with generated B:** mem[1] = identity, MUL src1=1 src2=5 `gen_in`=1 dst=1 → mem[1] all 5 (aliased dst), `done` at +65.
- **MUL wrap:** A and B all 0x10000 → every result element 0. A and B all 3 → every element 36.
- **SUB and TRN:** A[i][j]=4i+j, B all 1 → SUB gives 4i+j-1, with element (0,0) = 0xFFFFFFFF. TRN gives res[i][j]=4j+i.
- **Reset mid-MUL:** assert RST=0 at cycle +30 → `busy`/`write_enable` 0 immediately, dst unchanged, a fresh `start` after release completes normally.
- **start while busy:** pulse `start` with different `dst` at +5 of an ADD → ignored. Exactly one `write_enable` pulse, to the original `dst`.
